// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory store sequencer.
package dm_pkg;

  localparam int DM_LINE_BYTES = 8;

  typedef enum logic [1:0] {
    UNIT_B  = 2'd0,
    UNIT_HW = 2'd1,
    UNIT_W  = 2'd2,
    UNIT_DW = 2'd3
  } mem_unit_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    ERR   = 2'd3
  } dm_seq_state_e;

  function automatic logic [7:0] unit_mask(input mem_unit_e unit);
    case (unit)
      UNIT_B:  unit_mask = 8'h01;
      UNIT_HW: unit_mask = 8'h03;
      UNIT_W:  unit_mask = 8'h0F;
      UNIT_DW: unit_mask = 8'hFF;
      default: unit_mask = 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_shifter.sv
// Combinational byte-lane placement of a store across two adjacent 8-byte lines.
module dm_lane_shifter
  import dm_pkg::*;
(
  input  logic [2:0]   off,
  input  logic [1:0]   unit,
  input  logic [63:0]  data,
  output logic [15:0]  be16,
  output logic [127:0] wd128
);

  logic [7:0]  mask_s;
  logic [63:0] byte_mask_s;

  // Mask data to the store size, then slide enables and data into lane position.
  always_comb begin
    mask_s      = unit_mask(mem_unit_e'(unit));
    byte_mask_s = 64'h0;
    for (int i = 0; i < 8; i++) begin
      byte_mask_s[i*8 +: 8] = {8{mask_s[i]}};
    end
    be16  = {8'h00, mask_s} << off;
    wd128 = {64'h0, data & byte_mask_s} << {off, 3'b000};
  end

endmodule

// File: rtl/dm_store_sequencer.sv
// Store-issue controller: one or two DM line writes per store request.
// Line-crossing stores are split when DM_MISALIGN_SPLIT_EN is defined, rejected otherwise.
module dm_store_sequencer
  import dm_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int LINE_BYTES = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_data,
  input  logic [1:0]      i_req_unit,
  output logic            o_mem_en,
  output logic [XLEN-4:0] o_mem_line_addr,
  output logic [7:0]      o_mem_wr_en,
  output logic [63:0]     o_mem_wdata,
  input  logic            i_mem_ready,
  output logic            o_staller,
  output logic            o_done,
  output logic            o_miss_aligned_error
);

  localparam int LINE_W = XLEN - 3;

  if (LINE_BYTES != DM_LINE_BYTES) begin : g_line_bytes_check
    $error("dm_store_sequencer: LINE_BYTES must be 8");
  end

  dm_seq_state_e state_r, next_state_s;
  logic              accept_s, cross_s;
  logic [15:0]       be16_s;
  logic [127:0]      wd128_s;
  logic              mem_en_s, done_s, err_s;
  logic [LINE_W-1:0] line_s;
  logic [7:0]        wr_en_s;
  logic [63:0]       wdata_s;

  assign accept_s  = i_req_valid && o_req_ready;
  assign cross_s   = (be16_s[15:8] != 8'h00);
  assign o_staller = (state_r != IDLE) || (i_req_valid && (state_r == IDLE));

  dm_lane_shifter u_shift (
    .off   (i_req_addr[2:0]),
    .unit  (i_req_unit),
    .data  (i_req_data),
    .be16  (be16_s),
    .wd128 (wd128_s)
  );

`ifdef DM_MISALIGN_SPLIT_EN
  logic        cross_r;
  logic [7:0]  hi_be_r;
  logic [63:0] hi_wdata_r;

  // Upper-line half of the store, replayed by BEAT1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cross_r    <= 1'b0;
      hi_be_r    <= 8'h00;
      hi_wdata_r <= 64'h0;
    end else if (accept_s) begin
      cross_r    <= cross_s;
      hi_be_r    <= be16_s[15:8];
      hi_wdata_r <= wd128_s[127:64];
    end
  end
`else
  logic unused_hi_data_s;
  assign unused_hi_data_s = ^wd128_s[127:64];
`endif

  // Next state plus the next-cycle image of every registered output.
  always_comb begin
    next_state_s = state_r;
    mem_en_s     = o_mem_en;
    line_s       = o_mem_line_addr;
    wr_en_s      = o_mem_wr_en;
    wdata_s      = o_mem_wdata;
    done_s       = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifdef DM_MISALIGN_SPLIT_EN
          next_state_s = BEAT0;
          mem_en_s     = 1'b1;
          line_s       = i_req_addr[XLEN-1:3];
          wr_en_s      = be16_s[7:0];
          wdata_s      = wd128_s[63:0];
`else
          if (cross_s) begin
            next_state_s = ERR;
            err_s        = 1'b1;
          end else begin
            next_state_s = BEAT0;
            mem_en_s     = 1'b1;
            line_s       = i_req_addr[XLEN-1:3];
            wr_en_s      = be16_s[7:0];
            wdata_s      = wd128_s[63:0];
          end
`endif
        end else begin
          next_state_s = IDLE;
        end
      end
      BEAT0: begin
        if (i_mem_ready) begin
`ifdef DM_MISALIGN_SPLIT_EN
          if (cross_r) begin
            next_state_s = BEAT1;
            line_s       = o_mem_line_addr + LINE_W'(1);
            wr_en_s      = hi_be_r;
            wdata_s      = hi_wdata_r;
          end else begin
            next_state_s = IDLE;
            done_s       = 1'b1;
            mem_en_s     = 1'b0;
            line_s       = '0;
            wr_en_s      = 8'h00;
            wdata_s      = 64'h0;
          end
`else
          next_state_s = IDLE;
          done_s       = 1'b1;
          mem_en_s     = 1'b0;
          line_s       = '0;
          wr_en_s      = 8'h00;
          wdata_s      = 64'h0;
`endif
        end else begin
          next_state_s = BEAT0;
        end
      end
`ifdef DM_MISALIGN_SPLIT_EN
      BEAT1: begin
        if (i_mem_ready) begin
          next_state_s = IDLE;
          done_s       = 1'b1;
          mem_en_s     = 1'b0;
          line_s       = '0;
          wr_en_s      = 8'h00;
          wdata_s      = 64'h0;
        end else begin
          next_state_s = BEAT1;
        end
      end
`endif
      ERR: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
        mem_en_s     = 1'b0;
        line_s       = '0;
        wr_en_s      = 8'h00;
        wdata_s      = 64'h0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight store.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r              <= IDLE;
      o_req_ready          <= 1'b1;
      o_mem_en             <= 1'b0;
      o_mem_line_addr      <= '0;
      o_mem_wr_en          <= 8'h00;
      o_mem_wdata          <= 64'h0;
      o_done               <= 1'b0;
      o_miss_aligned_error <= 1'b0;
    end else begin
      state_r              <= next_state_s;
      o_req_ready          <= (next_state_s == IDLE);
      o_mem_en             <= mem_en_s;
      o_mem_line_addr      <= line_s;
      o_mem_wr_en          <= wr_en_s;
      o_mem_wdata          <= wdata_s;
      o_done               <= done_s;
      o_miss_aligned_error <= err_s;
    end
  end

endmodule

// File: tb/tb_dm_store_sequencer.sv
// Directed self-checking bench for dm_store_sequencer (both DM_MISALIGN_SPLIT_EN builds).
module tb_dm_store_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_unit;
  logic        mem_en;
  logic [60:0] mem_line_addr;
  logic [7:0]  mem_wr_en;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic        staller;
  logic        done;
  logic        mis_err;

  int n_cmp = 0;
  int n_bad = 0;

  dm_store_sequencer #(.XLEN(64), .LINE_BYTES(8)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_req_valid          (req_valid),
    .o_req_ready          (req_ready),
    .i_req_addr           (req_addr),
    .i_req_data           (req_data),
    .i_req_unit           (req_unit),
    .o_mem_en             (mem_en),
    .o_mem_line_addr      (mem_line_addr),
    .o_mem_wr_en          (mem_wr_en),
    .o_mem_wdata          (mem_wdata),
    .i_mem_ready          (mem_ready),
    .o_staller            (staller),
    .o_done               (done),
    .o_miss_aligned_error (mis_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [60:0] line, input logic [7:0] be,
                            input logic [63:0] wd);
    check({tag, ".en"},    mem_en, 1'b1);
    check({tag, ".line"},  mem_line_addr, line);
    check({tag, ".wr_en"}, mem_wr_en, be);
    check({tag, ".wdata"}, mem_wdata, wd);
    check({tag, ".ready"}, req_ready, 1'b0);
    check({tag, ".stall"}, staller, 1'b1);
    check({tag, ".done"},  done, 1'b0);
    check({tag, ".err"},   mis_err, 1'b0);
  endtask

  task automatic check_done(input string tag);
    check({tag, ".done"},  done, 1'b1);
    check({tag, ".en"},    mem_en, 1'b0);
    check({tag, ".ready"}, req_ready, 1'b1);
    check({tag, ".err"},   mis_err, 1'b0);
  endtask

  task automatic issue(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] unit);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_unit  = unit;
    #1;
    check("accept.stall", staller, 1'b1);
    check("accept.ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    req_addr  = 64'h0;
    req_data  = 64'h0;
  endtask

  task automatic check_reject(input string tag);
    check({tag, ".err"},   mis_err, 1'b1);
    check({tag, ".en"},    mem_en, 1'b0);
    check({tag, ".ready"}, req_ready, 1'b0);
    check({tag, ".done"},  done, 1'b0);
    tick();
    check({tag, ".err_clr"}, mis_err, 1'b0);
    check({tag, ".en2"},     mem_en, 1'b0);
    check({tag, ".ready2"},  req_ready, 1'b1);
    check({tag, ".done2"},   done, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 64'h0;
    req_data  = 64'h0;
    req_unit  = 2'd0;
    mem_ready = 1'b1;
    #2;
    check("rst.ready", req_ready, 1'b1);
    check("rst.en",    mem_en, 1'b0);
    check("rst.wr_en", mem_wr_en, 8'h00);
    check("rst.done",  done, 1'b0);
    check("rst.err",   mis_err, 1'b0);
    check("rst.stall", staller, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle.ready", req_ready, 1'b1);
    check("idle.stall", staller, 1'b0);

    // Byte store, single beat, done two cycles after accept.
    issue(64'h1003, 64'h0000_0000_0000_00AB, 2'd0);
    check_beat("sb", 61'h200, 8'h08, 64'h0000_0000_AB00_0000);
    tick();
    check_done("sb_done");
    tick();
    check("sb.done_pulse", done, 1'b0);

    // Halfword with garbage upper data bits that must be masked off.
    issue(64'h10, 64'hFFFF_FFFF_FFFF_1234, 2'd1);
    check_beat("sh_al", 61'h2, 8'h03, 64'h0000_0000_0000_1234);
    tick();
    check_done("sh_al_done");
    tick();

    // Word in the upper half of a line, no crossing.
    issue(64'h1004, 64'h0000_0000_DEAD_BEEF, 2'd2);
    check_beat("sw4", 61'h200, 8'hF0, 64'hDEAD_BEEF_0000_0000);
    tick();
    check_done("sw4_done");
    tick();

    // Word crossing a line boundary.
    issue(64'h1006, 64'h0000_0000_1122_3344, 2'd2);
`ifdef DM_MISALIGN_SPLIT_EN
    check_beat("swx0", 61'h200, 8'hC0, 64'h3344_0000_0000_0000);
    tick();
    check_beat("swx1", 61'h201, 8'h03, 64'h0000_0000_0000_1122);
    tick();
    check_done("swx_done");
    tick();
`else
    check_reject("swx");
    tick();
`endif

    // Doubleword with DM back-pressure for three cycles.
    mem_ready = 1'b0;
    issue(64'h2000, 64'h0123_4567_89AB_CDEF, 2'd3);
    for (int i = 0; i < 4; i++) begin
      check_beat("sd_hold", 61'h400, 8'hFF, 64'h0123_4567_89AB_CDEF);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    check_done("sd_done");
    tick();

    // Halfword at the very top of the address space.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_BEEF, 2'd1);
`ifdef DM_MISALIGN_SPLIT_EN
    check_beat("shw0", 61'h1FFF_FFFF_FFFF_FFFF, 8'h80, 64'hEF00_0000_0000_0000);
    tick();
    check_beat("shw1", 61'h0, 8'h01, 64'h0000_0000_0000_00BE);
    tick();
    check_done("shw_done");
    tick();
`else
    check_reject("shw");
    tick();
`endif

    // Reset in the middle of a store.
`ifdef DM_MISALIGN_SPLIT_EN
    issue(64'h1006, 64'h0000_0000_1122_3344, 2'd2);
    tick();
    check("mid.in_beat1", mem_line_addr, 61'h201);
    mem_ready = 1'b0;
`else
    mem_ready = 1'b0;
    issue(64'h1003, 64'h0000_0000_0000_00AB, 2'd0);
    check("mid.in_beat0", mem_en, 1'b1);
`endif
    #2;
    rst = 1'b1;
    #1;
    check("mid.en",    mem_en, 1'b0);
    check("mid.wr_en", mem_wr_en, 8'h00);
    check("mid.ready", req_ready, 1'b1);
    check("mid.done",  done, 1'b0);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("post.done", done, 1'b0);
    check("post.en",   mem_en, 1'b0);
    check("post.ready", req_ready, 1'b1);

    issue(64'h1003, 64'h0000_0000_0000_005A, 2'd0);
    check_beat("post_sb", 61'h200, 8'h08, 64'h0000_0000_5A00_0000);
    tick();
    check_done("post_sb_done");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
